// File: rtl/fa_serial_if.sv
// fa_serial_if: operand/result bundle for fa_serial_adder; ovf exists only with FA_SERIAL_OVF_EN
interface fa_serial_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             busy;
    logic             done;
`ifdef FA_SERIAL_OVF_EN
    logic             ovf;
    modport master(output start, a, b, ci, input s, co, busy, done, ovf);
    modport slave(input start, a, b, ci, output s, co, busy, done, ovf);
`else
    modport master(output start, a, b, ci, input s, co, busy, done);
    modport slave(input start, a, b, ci, output s, co, busy, done);
`endif
endinterface

// File: rtl/fa_serial_adder.sv
// fa_serial_adder: bit-serial WIDTH-bit adder on one full-adder cell; FA_SERIAL_OVF_EN adds ovf output
module fa_serial_adder #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    fa_serial_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] a_nx;
    assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign bit_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    // sum bits enter a_sh at the MSB as operand bits leave, so after WIDTH shifts it holds the sum
    assign a_nx = {bit_s, a_sh[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.s    <= '0;
            bus.co   <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
`ifdef FA_SERIAL_OVF_EN
            bus.ovf  <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                RUN: begin
                    a_sh  <= a_nx;
                    b_sh  <= b_sh >> 1;
                    carry <= bit_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.s    <= a_nx;
                        bus.co   <= bit_c;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
`ifdef FA_SERIAL_OVF_EN
                        bus.ovf  <= carry ^ bit_c;
`endif
                    end
                end
                default: begin
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        carry    <= bus.ci;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fa_serial_adder.sv
// tb_fa_serial_adder: random and directed checks of fa_serial_adder (WIDTH 8 and exhaustive WIDTH 3)
module tb_fa_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fa_serial_if #(.WIDTH(8)) bus8();
    fa_serial_if #(.WIDTH(3)) bus3();
    fa_serial_adder #(.WIDTH(8)) dut8(.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    fa_serial_adder #(.WIDTH(3)) dut3(.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int n_cmp = 0;
    int n_err = 0;
    int k = -1;
    int pend = 0;
    int pub = 0;
    bit pend_ovf = 1'b0;
    bit pub_ovf = 1'b0;
    bit exp_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_ovf(input int w, input int a, input int b, input int ci);
        int sa = a >= (1 << (w - 1)) ? a - (1 << w) : a;
        int sb = b >= (1 << (w - 1)) ? b - (1 << w) : b;
        int r = sa + sb + ci;
        return r > (1 << (w - 1)) - 1 || r < -(1 << (w - 1));
    endfunction

    // Reference: an op accepted at edge k=0 publishes at k=8; the DONE cycle then accepts again at k=9.
    task automatic step8();
        @(posedge clk);
        if (k >= 0) k++;
        exp_done = 1'b0;
        if (k == 8) begin
            exp_done = 1'b1;
            pub = pend;
            pub_ovf = pend_ovf;
        end else if ((k < 0 || k == 9) && bus8.start) begin
            pend = int'(bus8.a) + int'(bus8.b) + int'(bus8.ci);
            pend_ovf = ref_ovf(8, int'(bus8.a), int'(bus8.b), int'(bus8.ci));
            k = 0;
        end else if (k == 9) begin
            k = -1;
        end
        #1;
        check("done", 32'(bus8.done), 32'(exp_done));
        check("busy", 32'(bus8.busy), 32'(k >= 0 && k < 8));
        check("busy_done_excl", 32'(bus8.busy & bus8.done), 32'd0);
        if (exp_done) begin
            check("sum", 32'({bus8.co, bus8.s}), 32'(pub));
`ifdef FA_SERIAL_OVF_EN
            check("ovf", 32'(bus8.ovf), 32'(pub_ovf));
`endif
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus8.a = a;
        bus8.b = b;
        bus8.ci = ci;
        bus8.start = 1'b1;
        step8();
        bus8.start = 1'b0;
        repeat (9) step8();
    endtask

    initial begin
        int t;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0;
        bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.ci = 1'b0;
        #2;
        check("rst_sum", 32'({bus8.co, bus8.s}), 32'd0);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        #2 rst_n = 1'b1;
        run_op(8'h5A, 8'h33, 1'b0);
        check("t1_sum", 32'({bus8.co, bus8.s}), 32'h08D);
`ifdef FA_SERIAL_OVF_EN
        check("t1_ovf", 32'(bus8.ovf), 32'd1);
`endif
        run_op(8'hFF, 8'h01, 1'b0);
        check("t2a_sum", 32'({bus8.co, bus8.s}), 32'h100);
`ifdef FA_SERIAL_OVF_EN
        check("t2a_ovf", 32'(bus8.ovf), 32'd0);
`endif
        run_op(8'hFF, 8'hFF, 1'b1);
        check("t2b_sum", 32'({bus8.co, bus8.s}), 32'h1FF);
`ifdef FA_SERIAL_OVF_EN
        check("t2b_ovf", 32'(bus8.ovf), 32'd0);
`endif
        for (int i = 0; i < 30; i++) begin
            bus8.start = 1'b1;
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            bus8.ci = 1'($urandom);
            step8();
        end
        bus8.start = 1'b0;
        repeat (10) step8();
        // async reset mid-operation must clear everything without waiting for a clock edge
        bus8.a = 8'hC3; bus8.b = 8'h7E; bus8.ci = 1'b1; bus8.start = 1'b1;
        step8();
        bus8.start = 1'b0;
        repeat (4) step8();
        #2 rst_n = 1'b0;
        #1;
        check("t4_busy", 32'(bus8.busy), 32'd0);
        check("t4_done", 32'(bus8.done), 32'd0);
        check("t4_sum", 32'({bus8.co, bus8.s}), 32'd0);
        k = -1;
        #2 rst_n = 1'b1;
        run_op(8'h10, 8'h20, 1'b0);
        check("t4_after", 32'({bus8.co, bus8.s}), 32'h030);
        for (int i = 0; i < 400; i++) begin
            bus8.start = ($urandom_range(0, 3) == 0);
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            bus8.ci = 1'($urandom);
            step8();
        end
        bus8.start = 1'b0;
        repeat (10) step8();
        for (int i = 0; i < 128; i++) begin
            bus3.a = 3'(i & 7);
            bus3.b = 3'((i >> 3) & 7);
            bus3.ci = 1'((i >> 6) & 1);
            bus3.start = 1'b1;
            @(posedge clk);
            #1 bus3.start = 1'b0;
            t = 0;
            while (!bus3.done && t < 10) begin
                @(posedge clk);
                #1 t++;
            end
            check("w3_latency", 32'(t), 32'd3);
            check("w3_sum", 32'({bus3.co, bus3.s}), 32'((i & 7) + ((i >> 3) & 7) + ((i >> 6) & 1)));
`ifdef FA_SERIAL_OVF_EN
            check("w3_ovf", 32'(bus3.ovf), 32'(ref_ovf(3, i & 7, (i >> 3) & 7, (i >> 6) & 1)));
`endif
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
